// File: rtl/loopback_rd_scheduler.sv
// rtl/loopback_rd_scheduler.sv - read-side burst scheduler with FIFO credit control for the loopback datapath
module loopback_rd_scheduler #(
  parameter int BURST_LINES = 64,
  parameter int FIFO_DEPTH  = 512,
  parameter int CNT_W       = 32,
  localparam int LEN_W      = $clog2(BURST_LINES) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_lines,
  output logic             rd_req_valid,
  output logic [CNT_W-1:0] rd_req_offset,
  output logic [LEN_W-1:0] rd_req_len,
  input  logic             rd_req_ready,
  input  logic             rd_rsp_valid,
  input  logic             wr_done,
  output logic             busy,
  output logic             finish,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_REQ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_total_q, len_total_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             rd_req_valid_q, rd_req_valid_d;
  logic [CNT_W-1:0] rd_req_offset_q, rd_req_offset_d;
  logic [LEN_W-1:0] rd_req_len_q, rd_req_len_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;
  logic             error_q, error_d;

  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] burst_len;
  logic [CNT_W:0]   credit_need;
  logic             credit_ok;
  logic             active;
  logic             rsp_inc;
  logic             wr_inc;
  logic             err_evt;
  logic [CNT_W-1:0] req_next;

  // State and datapath registers; asynchronous reset returns everything to IDLE/zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      len_total_q     <= '0;
      req_cnt_q       <= '0;
      rsp_cnt_q       <= '0;
      wr_cnt_q        <= '0;
      rd_req_valid_q  <= 1'b0;
      rd_req_offset_q <= '0;
      rd_req_len_q    <= '0;
      busy_q          <= 1'b0;
      finish_q        <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_total_q     <= len_total_d;
      req_cnt_q       <= req_cnt_d;
      rsp_cnt_q       <= rsp_cnt_d;
      wr_cnt_q        <= wr_cnt_d;
      rd_req_valid_q  <= rd_req_valid_d;
      rd_req_offset_q <= rd_req_offset_d;
      rd_req_len_q    <= rd_req_len_d;
      busy_q          <= busy_d;
      finish_q        <= finish_d;
      error_q         <= error_d;
    end
  end

  // Next-state: burst sizing, credit check, response/write accounting and protocol error detection
  always_comb begin
    state_d         = state_q;
    len_total_d     = len_total_q;
    req_cnt_d       = req_cnt_q;
    rsp_cnt_d       = rsp_cnt_q;
    wr_cnt_d        = wr_cnt_q;
    rd_req_valid_d  = rd_req_valid_q;
    rd_req_offset_d = rd_req_offset_q;
    rd_req_len_d    = rd_req_len_q;
    busy_d          = busy_q;
    finish_d        = finish_q;

    rem       = len_total_q - req_cnt_q;
    burst_len = (rem < CNT_W'(BURST_LINES)) ? rem : CNT_W'(BURST_LINES);
    // Lines already requested but not yet written back still occupy FIFO slots
    credit_need = {1'b0, req_cnt_q - wr_cnt_q} + {1'b0, burst_len};
    credit_ok   = (credit_need <= (CNT_W+1)'(FIFO_DEPTH));
    req_next    = req_cnt_q + CNT_W'(rd_req_len_q);

    active  = (state_q == S_ISSUE) || (state_q == S_REQ) || (state_q == S_DRAIN);
    rsp_inc = rd_rsp_valid && active && (rsp_cnt_q != req_cnt_q);
    wr_inc  = wr_done && active && (wr_cnt_q != rsp_cnt_q);
    err_evt = (rd_rsp_valid && !rsp_inc) || (wr_done && !wr_inc);
    error_d = error_q | err_evt;

    if (rsp_inc) rsp_cnt_d = rsp_cnt_q + 1'b1;
    if (wr_inc)  wr_cnt_d  = wr_cnt_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_total_d = num_lines;
          req_cnt_d   = '0;
          rsp_cnt_d   = '0;
          wr_cnt_d    = '0;
          error_d     = err_evt;
          if (num_lines == '0) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
            busy_d   = 1'b0;
          end else begin
            state_d  = S_ISSUE;
            finish_d = 1'b0;
            busy_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          rd_req_valid_d  = 1'b1;
          rd_req_offset_d = req_cnt_q;
          rd_req_len_d    = burst_len[LEN_W-1:0];
          state_d         = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_req_ready) begin
          req_cnt_d      = req_next;
          rd_req_valid_d = 1'b0;
          state_d        = (req_next < len_total_q) ? S_ISSUE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Look at the post-increment count so finish follows the last write by one cycle
        if (wr_cnt_d == len_total_q) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          finish_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_req_valid  = rd_req_valid_q;
  assign rd_req_offset = rd_req_offset_q;
  assign rd_req_len    = rd_req_len_q;
  assign busy          = busy_q;
  assign finish        = finish_q;
  assign error         = error_q;

endmodule

// File: tb/tb_loopback_rd_scheduler.sv
// tb/tb_loopback_rd_scheduler.sv - directed self-checking bench for loopback_rd_scheduler
module tb_loopback_rd_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] num_lines;
  logic        rd_req_ready;
  logic        rd_rsp_valid;
  logic        wr_done;
  logic        sel;

  logic        a_valid, a_busy, a_finish, a_error;
  logic [31:0] a_offset;
  logic [6:0]  a_len;
  logic        b_valid, b_busy, b_finish, b_error;
  logic [31:0] b_offset;
  logic [6:0]  b_len;

  logic        obs_valid, obs_busy, obs_finish, obs_error;
  logic [31:0] obs_offset;
  logic [6:0]  obs_len;

  loopback_rd_scheduler #(.BURST_LINES(64), .FIFO_DEPTH(512), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .start(start), .num_lines(num_lines),
    .rd_req_valid(a_valid), .rd_req_offset(a_offset), .rd_req_len(a_len),
    .rd_req_ready(rd_req_ready), .rd_rsp_valid(rd_rsp_valid), .wr_done(wr_done),
    .busy(a_busy), .finish(a_finish), .error(a_error)
  );

  loopback_rd_scheduler #(.BURST_LINES(64), .FIFO_DEPTH(128), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .start(start), .num_lines(num_lines),
    .rd_req_valid(b_valid), .rd_req_offset(b_offset), .rd_req_len(b_len),
    .rd_req_ready(rd_req_ready), .rd_rsp_valid(rd_rsp_valid), .wr_done(wr_done),
    .busy(b_busy), .finish(b_finish), .error(b_error)
  );

  assign obs_valid  = sel ? b_valid  : a_valid;
  assign obs_offset = sel ? b_offset : a_offset;
  assign obs_len    = sel ? b_len    : a_len;
  assign obs_busy   = sel ? b_busy   : a_busy;
  assign obs_finish = sel ? b_finish : a_finish;
  assign obs_error  = sel ? b_error  : a_error;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int req_acc, rsp_sent, wr_sent, last_wr_cyc, fin_cyc;
  int req_off[$];
  int req_len[$];
  int req_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic begin_test();
    req_acc = 0; rsp_sent = 0; wr_sent = 0; last_wr_cyc = -1; fin_cyc = -1;
    req_off.delete(); req_len.delete(); req_cyc.delete();
  endtask

  task automatic tick();
    bit acc;
    int len;
    acc = obs_valid && rd_req_ready;
    len = int'(obs_len);
    if (acc) begin
      req_off.push_back(int'(obs_offset));
      req_len.push_back(len);
      req_cyc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    if (acc) req_acc += len;
    if (rd_rsp_valid) rsp_sent++;
    if (wr_done) begin
      wr_sent++;
      last_wr_cyc = cyc;
    end
    if (obs_finish && fin_cyc < 0) fin_cyc = cyc;
    cyc++;
  endtask

  task automatic serve(input int max_cyc, input bit auto_wr, input bit until_fin);
    for (int i = 0; i < max_cyc; i++) begin
      if (until_fin && obs_finish) break;
      rd_rsp_valid = (rsp_sent < req_acc);
      wr_done      = auto_wr && (wr_sent < rsp_sent);
      tick();
    end
    rd_rsp_valid = 1'b0;
    wr_done      = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic do_start(input logic [31:0] n);
    num_lines = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Directed scenario sequence
  initial begin
    int s;
    int w;
    reset = 1'b1; start = 1'b0; num_lines = '0; rd_req_ready = 1'b1;
    rd_rsp_valid = 1'b0; wr_done = 1'b0; sel = 1'b0;
    begin_test();
    tick(); tick();
    check("rst_valid",  obs_valid,  0);
    check("rst_busy",   obs_busy,   0);
    check("rst_finish", obs_finish, 0);
    check("rst_error",  obs_error,  0);
    reset = 1'b0;
    tick();

    // write completion while idle is a protocol error
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    check("idle_wr_err", obs_error, 1);

    // 512 lines, full credit: eight back-to-back bursts with one idle cycle between
    begin_test();
    s = cyc;
    do_start(512);
    check("t1_busy", obs_busy, 1);
    check("t1_err_cleared", obs_error, 0);
    serve(3000, 1'b1, 1'b1);
    check("t1_nreq", req_off.size(), 8);
    for (int i = 0; i < 8 && i < req_off.size(); i++) begin
      check("t1_off", req_off[i], 64 * i);
      check("t1_len", req_len[i], 64);
      check("t1_cyc", req_cyc[i], s + 2 + 2 * i);
    end
    check("t1_finish", obs_finish, 1);
    check("t1_fin_lat", fin_cyc, last_wr_cyc);
    check("t1_wr", wr_sent, 512);
    check("t1_busy_end", obs_busy, 0);
    check("t1_error", obs_error, 0);

    // 100 lines: full burst then a 36-line tail
    begin_test();
    s = cyc;
    do_start(100);
    check("t2_finish_clr", obs_finish, 0);
    serve(1000, 1'b1, 1'b1);
    check("t2_nreq", req_off.size(), 2);
    if (req_off.size() >= 2) begin
      check("t2_off0", req_off[0], 0);
      check("t2_len0", req_len[0], 64);
      check("t2_off1", req_off[1], 64);
      check("t2_len1", req_len[1], 36);
      check("t2_cyc0", req_cyc[0], s + 2);
    end
    check("t2_finish", obs_finish, 1);
    check("t2_fin_lat", fin_cyc, last_wr_cyc);
    check("t2_wr", wr_sent, 100);
    check("t2_error", obs_error, 0);

    // FIFO depth 128: two bursts fill the credit; third waits for 64 writes
    sel = 1'b1;
    pulse_reset();
    begin_test();
    do_start(256);
    serve(150, 1'b0, 1'b0);
    check("t3_nreq_stall", req_off.size(), 2);
    check("t3_rsp", rsp_sent, 128);
    check("t3_valid_stall", obs_valid, 0);
    check("t3_busy", obs_busy, 1);
    for (int i = 0; i < 64; i++) begin
      wr_done = 1'b1;
      tick();
    end
    wr_done = 1'b0;
    w = last_wr_cyc;
    serve(5, 1'b0, 1'b0);
    check("t3_nreq3", req_off.size(), 3);
    if (req_off.size() >= 3) begin
      check("t3_off2", req_off[2], 128);
      check("t3_cyc2", req_cyc[2], w + 2);
    end
    serve(2000, 1'b1, 1'b1);
    check("t3_nreq_all", req_off.size(), 4);
    check("t3_finish", obs_finish, 1);
    check("t3_error", obs_error, 0);

    // zero-length transfer: straight to done, never busy, no request
    sel = 1'b0;
    pulse_reset();
    begin_test();
    do_start(0);
    check("t4_busy0", obs_busy, 0);
    check("t4_valid0", obs_valid, 0);
    tick();
    check("t4_finish", obs_finish, 1);
    check("t4_busy1", obs_busy, 0);
    check("t4_valid1", obs_valid, 0);
    tick();
    check("t4_busy2", obs_busy, 0);

    // backpressure: request held stable for 10 cycles
    begin_test();
    rd_req_ready = 1'b0;
    s = cyc;
    do_start(64);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", obs_valid, 1);
      check("t5_hold_off", obs_offset, 0);
      check("t5_hold_len", obs_len, 64);
      tick();
    end
    rd_req_ready = 1'b1;
    serve(500, 1'b1, 1'b1);
    check("t5_nreq", req_off.size(), 1);
    if (req_off.size() >= 1) check("t5_acc_cyc", req_cyc[0], s + 12);
    check("t5_finish", obs_finish, 1);
    check("t5_error", obs_error, 0);

    // response with nothing outstanding, then reset mid-transfer and a clean rerun
    begin_test();
    rd_req_ready = 1'b0;
    do_start(64);
    tick();
    rd_rsp_valid = 1'b1; tick(); rd_rsp_valid = 1'b0;
    check("t6_err", obs_error, 1);
    check("t6_busy", obs_busy, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_valid",  obs_valid,  0);
    check("t6_rst_busy",   obs_busy,   0);
    check("t6_rst_finish", obs_finish, 0);
    check("t6_rst_error",  obs_error,  0);
    tick();
    reset = 1'b0;
    rd_req_ready = 1'b1;
    tick();
    begin_test();
    do_start(64);
    serve(500, 1'b1, 1'b1);
    check("t6_nreq", req_off.size(), 1);
    check("t6_finish", obs_finish, 1);
    check("t6_error", obs_error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
